// File: rtl/vio_pkg.sv
// Shared definitions for the virtual-button event path: event kinds,
// constant-width helper and nothing clocked.
// Latency/backpressure: not applicable (package only).
package vio_pkg;

  // Kind bit carried in the MSB of every queued event word.
  typedef enum logic {
    EVT_RELEASE = 1'b0,
    EVT_PRESS   = 1'b1
  } evt_kind_e;

  // Ceiling log2 for sizing counters and indices at elaboration time.
  // Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/vio_sync_fifo.sv
// Single-clock show-ahead FIFO; rd_data is the head entry whenever empty=0.
// Latency: a write is visible at rd_data the cycle after wr_en (empty drops then).
// Backpressure: wr_en ignored while full (full sampled at cycle start, so
//   write+read on a full FIFO only reads); rd_en ignored while empty.
// Ports: i_clk, rst (sync, active-low); wr_en/wr_data/full; rd_en/rd_data/empty.
module vio_sync_fifo
  import vio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  // Last popped head, presented while empty so rd_data never wanders.
  logic [WIDTH-1:0] last_q;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/vio_button_events.sv
// Debounces the virtual button bus, keeps per-button press toggles and
// queues press/release events. Latency: event pushed one cycle after the
// debounced flip. Backpressure: evt_ready stalls the queue; a full queue holds
// events in per-channel pending bits, a second flip on a pending channel sets
// the sticky evt_overflow.
// Ports: i_clk, rst (sync, active-low); buttons -> btn_stable/btn_toggle;
//   evt_valid/evt_ready/evt_data {kind,index}; evt_overflow cleared by ovf_clr.
module vio_button_events
  import vio_pkg::*;
#(
  parameter int N_BTN      = 16,
  parameter int CLK_HZ     = 25000000,
  parameter int TICK_HZ    = 1000,
  parameter int DEB_TICKS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   rst,
  input  logic [N_BTN-1:0]       buttons,
  output logic [N_BTN-1:0]       btn_stable,
  output logic [N_BTN-1:0]       btn_toggle,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [clog2(N_BTN):0]  evt_data,
  output logic                   evt_overflow,
  input  logic                   ovf_clr
);

  localparam int IDX_W    = clog2(N_BTN);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = clog2(TICK_DIV);
  localparam int CNT_W    = clog2(DEB_TICKS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

  typedef struct packed {
    evt_kind_e        kind;
    logic [IDX_W-1:0] idx;
  } evt_t;

  logic [N_BTN-1:0] in_q;
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [CNT_W-1:0] deb_cnt [N_BTN];
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] kind_q;
  logic [N_BTN-1:0] push_clr;
  logic             scan_hit;
  logic [IDX_W-1:0] scan_idx;
  logic             push;
  evt_t             push_word;
  logic             fifo_full;
  logic             fifo_empty;

  // Input register: the debouncer only ever sees a clean registered copy.
  always_ff @(posedge i_clk) begin
    if (!rst) in_q <= '0;
    else      in_q <= buttons;
  end

  // Sample-rate prescaler; tick is high for the single cycle at the wrap.
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge i_clk) begin
    if (!rst)      presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // A channel flips on the tick where it has already disagreed for
  // DEB_TICKS-1 ticks in a row and still disagrees.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++)
      flip[i] = tick && (in_q[i] != btn_stable[i]) && (deb_cnt[i] == CNT_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
      btn_stable <= '0;
      btn_toggle <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (in_q[i] == btn_stable[i]) deb_cnt[i] <= '0;
        else if (flip[i])             deb_cnt[i] <= '0;
        else                          deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
      btn_stable <= btn_stable ^ flip;
      // New level equals in_q on a flip, so flip & in_q marks the 0->1 edges.
      btn_toggle <= btn_toggle ^ (flip & in_q);
    end
  end

  // Scanner: lowest pending index wins (descending loop, last hit sticks).
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i]) begin
        scan_hit = 1'b1;
        scan_idx = IDX_W'(i);
      end
    end
  end

  assign push = scan_hit && !fifo_full;

  always_comb begin
    push_clr = '0;
    if (push) push_clr[scan_idx] = 1'b1;
    push_word = '{kind: evt_kind_e'(kind_q[scan_idx]), idx: scan_idx};
  end

  // Pending bits and their latched kind. An overwrite is only a loss when
  // the older event is not leaving for the queue in this same cycle.
  always_ff @(posedge i_clk) begin
    if (!rst) begin
      pend         <= '0;
      kind_q       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend   <= (pend & ~push_clr) | flip;
      kind_q <= (kind_q & ~flip) | (flip & in_q);
      if (|(flip & pend & ~push_clr)) evt_overflow <= 1'b1;
      else if (ovf_clr)               evt_overflow <= 1'b0;
    end
  end

  vio_sync_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .i_clk   (i_clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_word),
    .full    (fifo_full),
    .rd_en   (evt_ready),
    .rd_data (evt_data),
    .empty   (fifo_empty)
  );

  assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_vio_button_events.sv
// Directed bench for vio_button_events: 10 clocks per debounce tick,
// four ticks to flip, eight-entry event queue.
module tb_vio_button_events;

  logic        i_clk;
  logic        rst;
  logic [15:0] buttons;
  logic [15:0] btn_stable;
  logic [15:0] btn_toggle;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_data;
  logic        evt_overflow;
  logic        ovf_clr;

  int n_checks;
  int n_errors;

  logic [4:0] got_q[$];
  int         at_q[$];

  typedef struct {
    logic [15:0] btn;
    logic        rdy;
    logic        clr;
    int          cyc;
    logic [15:0] stb;
    logic [15:0] tgl;
    logic        vld;
    logic [4:0]  dat;
    logic        ovf;
  } vec_t;

  vio_button_events #(
    .N_BTN      (16),
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .DEB_TICKS  (4),
    .FIFO_DEPTH (8)
  ) dut (
    .i_clk        (i_clk),
    .rst          (rst),
    .buttons      (buttons),
    .btn_stable   (btn_stable),
    .btn_toggle   (btn_toggle),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stable"},   32'(btn_stable),   32'h0);
    chk({tag, "_toggle"},   32'(btn_toggle),   32'h0);
    chk({tag, "_valid"},    32'(evt_valid),    32'h0);
    chk({tag, "_data"},     32'(evt_data),     32'h0);
    chk({tag, "_overflow"}, 32'(evt_overflow), 32'h0);
  endtask

  // Called just after the negedge where rst was raised: the next posedge is
  // P1, ticks land on P10/P20/P30/P40, so the flip is at P40 and the first
  // event is pushed at P41.
  task automatic release_timing(input string tag, input logic [15:0] exp_stb,
                                input logic [4:0] exp_dat);
    for (int n = 1; n <= 41; n++) begin
      @(negedge i_clk);
      if (n == 39) chk({tag, "_stable_before_flip"}, 32'(btn_stable), 32'h0);
      if (n == 40) begin
        chk({tag, "_stable_at_flip"}, 32'(btn_stable), 32'(exp_stb));
        chk({tag, "_toggle_at_flip"}, 32'(btn_toggle), 32'(exp_stb));
        chk({tag, "_valid_at_flip"},  32'(evt_valid),  32'h0);
      end
      if (n == 41) begin
        chk({tag, "_valid_after_push"}, 32'(evt_valid), 32'h1);
        chk({tag, "_data_after_push"},  32'(evt_data),  32'(exp_dat));
      end
    end
  endtask

  // Accept everything for ncyc cycles, logging each head and its cycle.
  task automatic collect(input int ncyc);
    got_q.delete();
    at_q.delete();
    evt_ready = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      if (evt_valid) begin
        got_q.push_back(evt_data);
        at_q.push_back(n);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [4:0] exp[$], input bit back_to_back);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      if (k < got_q.size())
        chk($sformatf("%s_evt%0d", tag, k), 32'(got_q[k]), 32'(exp[k]));
      if (back_to_back && k > 0 && k < at_q.size())
        chk($sformatf("%s_gap%0d", tag, k), 32'(at_q[k] - at_q[k-1]), 32'h1);
    end
  endtask

  task automatic apply_vec(input int id, input vec_t v);
    buttons   = v.btn;
    evt_ready = v.rdy;
    ovf_clr   = v.clr;
    repeat (v.cyc) @(negedge i_clk);
    chk($sformatf("vec%0d_stable", id),   32'(btn_stable),   32'(v.stb));
    chk($sformatf("vec%0d_toggle", id),   32'(btn_toggle),   32'(v.tgl));
    chk($sformatf("vec%0d_valid", id),    32'(evt_valid),    32'(v.vld));
    chk($sformatf("vec%0d_data", id),     32'(evt_data),     32'(v.dat));
    chk($sformatf("vec%0d_overflow", id), 32'(evt_overflow), 32'(v.ovf));
  endtask

  initial begin
    vec_t       tbl[$];
    logic [4:0] exp_q[$];

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    buttons   = 16'h0004;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    //                btn      rdy clr cyc stable   toggle   vld dat    ovf
    // glitch on button 5 lasting two ticks
    tbl.push_back('{16'h0024, 0, 0, 20, 16'h0004, 16'h0004, 0, 5'h12, 0});
    tbl.push_back('{16'h0004, 0, 0, 50, 16'h0004, 16'h0004, 0, 5'h12, 0});
    // release button 2, consumed at once; data holds last head {0,2}
    tbl.push_back('{16'h0000, 1, 0, 60, 16'h0000, 16'h0004, 0, 5'h02, 0});
    // index 3..: used after the 0x8001 sequence (toggle now 0x8005)
    tbl.push_back('{16'h00DA, 0, 0, 60, 16'h00DA, 16'h80DF, 1, 5'h11, 0});
    tbl.push_back('{16'h0080, 0, 0, 60, 16'h0080, 16'h80DF, 1, 5'h11, 0});
    // index 5..: fill with presses 8..15, pend button 0, re-flip it
    tbl.push_back('{16'hFF80, 0, 0, 60, 16'hFF80, 16'h7FDF, 1, 5'h18, 0});
    tbl.push_back('{16'hFF81, 0, 0, 60, 16'hFF81, 16'h7FDE, 1, 5'h18, 0});
    tbl.push_back('{16'hFF80, 0, 0, 60, 16'hFF80, 16'h7FDE, 1, 5'h18, 1});
    tbl.push_back('{16'hFF80, 0, 0,  5, 16'hFF80, 16'h7FDE, 1, 5'h18, 1});
    tbl.push_back('{16'hFF80, 0, 1,  1, 16'hFF80, 16'h7FDE, 1, 5'h18, 0});
    tbl.push_back('{16'hFF80, 0, 0,  3, 16'hFF80, 16'h7FDE, 1, 5'h18, 0});
    // index 11: three releases queued before the reset
    tbl.push_back('{16'hF880, 0, 0, 60, 16'hF880, 16'h7FDE, 1, 5'h08, 0});

    // Reset state, then button 2 held across reset release
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    rst = 1'b1;
    release_timing("press2", 16'h0004, 5'h12);
    evt_ready = 1'b1;
    @(negedge i_clk);
    evt_ready = 1'b0;
    chk("pop2_valid", 32'(evt_valid), 32'h0);
    chk("pop2_data_held", 32'(evt_data), 32'h12);

    // Glitch rejection and release of button 2
    for (int i = 0; i <= 2; i++) apply_vec(i, tbl[i]);

    // Simultaneous presses of 0 and 15 drain in index order, back to back
    buttons = 16'h8001;
    collect(60);
    exp_q = '{5'h10, 5'h1F};
    chk_seq("press_0_15", exp_q, 1'b1);
    buttons = 16'h0000;
    collect(60);
    exp_q = '{5'h00, 5'h0F};
    chk_seq("release_0_15", exp_q, 1'b1);
    chk("toggle_after_0_15", 32'(btn_toggle), 32'h8005);

    // Nine events with the consumer stalled: eight queued, one pending
    for (int i = 3; i <= 4; i++) apply_vec(i, tbl[i]);
    collect(40);
    exp_q = '{5'h11, 5'h13, 5'h14, 5'h16, 5'h17, 5'h01, 5'h03, 5'h04, 5'h06};
    chk_seq("nine_events", exp_q, 1'b0);

    // Overfill, overwrite the pending channel, clear the sticky flag
    for (int i = 5; i <= 10; i++) apply_vec(i, tbl[i]);
    collect(40);
    exp_q = '{5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F, 5'h00};
    chk_seq("overflow_drain", exp_q, 1'b0);

    // Reset with three queued events; held buttons re-reported afterwards
    apply_vec(11, tbl[11]);
    rst = 1'b0;
    @(negedge i_clk);
    chk_all_zero("midrun_reset");
    rst = 1'b1;
    release_timing("rereport", 16'hF880, 5'h17);
    collect(30);
    exp_q = '{5'h17, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F};
    chk_seq("rereport", exp_q, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
